// File: rtl/add_seq_ctrl.sv
// Word-serial multi-word adder: one shared 32-bit adder, LSW first, WORDS+1 cycles start-to-done.
// Optional `ADD_SEQ_SUB_EN adds a sub input selecting a + ~b + 1.
module add_seq_ctrl #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  ci,
`ifdef ADD_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   s,
    output logic                  co
);

    localparam int unsigned W    = 32 * WORDS;
    localparam int unsigned IdxW = $clog2(WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, b_q, s_q;
    logic [IdxW-1:0] idx_q;
    logic            carry_q, co_q, busy_q, done_q;
    logic [W-1:0]    b_in;
    logic            c_in;
    logic [31:0]     word_sum;
    logic            word_co;

`ifdef ADD_SEQ_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : ci;
`else
    assign b_in = b;
    assign c_in = ci;
`endif

    // Operands are shifted right each RUN cycle, so the shared adder always sees the low word.
    assign {word_co, word_sum} = {1'b0, a_q[31:0]} + {1'b0, b_q[31:0]} + {32'b0, carry_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (idx_q == LastIdx) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_in;
                        carry_q <= c_in;
                        idx_q   <= '0;
                    end
                end
                StRun: begin
                    // Result words enter at the top; after WORDS shifts word 0 sits at the bottom.
                    s_q     <= {word_sum, s_q[W-1:32]};
                    a_q     <= {32'b0, a_q[W-1:32]};
                    b_q     <= {32'b0, b_q[W-1:32]};
                    carry_q <= word_co;
                    idx_q   <= idx_q + IdxW'(1);
                    if (idx_q == LastIdx) co_q <= word_co;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (WORDS=4); define ADD_SEQ_SUB_EN to also cover subtraction.
module tb_add_seq_ctrl;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 32 * WORDS;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         ci;
    logic         busy, done, co;
    logic [W-1:0] s;
`ifdef ADD_SEQ_SUB_EN
    logic         sub;
`endif

    int vectors     = 0;
    int miscompares = 0;

    add_seq_ctrl #(.WORDS(WORDS)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef ADD_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation; extra_at pulses start at edge N+extra_at, scramble changes operands after N.
    task automatic do_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_ci, input int extra_at, input logic scramble,
                         input logic [W-1:0] exp_s, input logic exp_co);
        int busy_cnt, done_cnt, lat;
        a = op_a;
        b = op_b;
        ci = op_ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) begin
            a  = ~op_a;
            b  = op_b ^ {W{1'b1}};
            ci = ~op_ci;
        end
        busy_cnt = busy ? 1 : 0;
        done_cnt = done ? 1 : 0;
        lat = 0;
        for (int i = 1; i <= 7; i++) begin
            start = (i == extra_at);
            tick();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) lat = i + 1;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, W'(lat), W'(WORDS + 1));
        check({tag, " busy_cycles"}, W'(busy_cnt), W'(WORDS + 1));
        check({tag, " done_pulses"}, W'(done_cnt), W'(1));
        check({tag, " s"}, s, exp_s);
        check({tag, " co"}, W'(co), W'(exp_co));
    endtask

    initial begin
        logic [W-1:0] ones;
        int t, first_done, second_done, done_cnt;
        ones  = {W{1'b1}};
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        ci = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        sub = 1'b0;
`endif
        tick();
        tick();
        check("reset busy", W'(busy), '0);
        check("reset done", W'(done), '0);
        check("reset s", s, '0);
        check("reset co", W'(co), '0);

        // Start presented on the very first edge with reset low.
        reset = 1'b0;
        do_op("zero", '0, '0, 1'b0, 0, 1'b0, '0, 1'b0);
        do_op("ripple", ones, '0, 1'b1, 0, 1'b0, '0, 1'b1);
        do_op("interleave", 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF,
              128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 1'b0, 2, 1'b0, ones, 1'b0);
        do_op("stable", 128'h135FA562, 128'h35614642, 1'b0, 0, 1'b1, 128'h48C0EBA4, 1'b0);
        do_op("midcarry", 128'h00000000_FFFFFFFF_FFFFFFFF_00000001, 128'hFFFFFFFF, 1'b0, 0,
              1'b0, 128'h00000001_00000000_00000000_00000000, 1'b0);
        do_op("overflow", ones, ones, 1'b1, 0, 1'b0, ones, 1'b1);

        // Abort two edges after start.
        a = ones;
        b = 128'h1;
        ci = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", W'(busy), '0);
        check("abort done", W'(done), '0);
        check("abort s", s, '0);
        check("abort co", W'(co), '0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort no_done", W'(done_cnt), '0);
        do_op("after_abort", 128'h1, 128'h2, 1'b1, 0, 1'b0, 128'h4, 1'b0);

        // Start held high: one launch every WORDS+2 cycles.
        a = 128'h1;
        b = 128'h1;
        ci = 1'b0;
        start = 1'b1;
        first_done = -1;
        second_done = -1;
        for (t = 0; t < 20; t++) begin
            tick();
            if (done) begin
                if (first_done < 0) first_done = t;
                else if (second_done < 0) second_done = t;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("b2b period", W'(second_done - first_done), W'(WORDS + 2));
        check("b2b s", s, 128'h2);

`ifdef ADD_SEQ_SUB_EN
        sub = 1'b1;
        do_op("sub 5-7", 128'h5, 128'h7, 1'b0, 0, 1'b0, ones - 128'h1, 1'b0);
        do_op("sub 7-5", 128'h7, 128'h5, 1'b1, 0, 1'b0, 128'h2, 1'b1);
        sub = 1'b0;
        do_op("sub0 add", 128'h7, 128'h5, 1'b1, 0, 1'b0, 128'hD, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter: WORDS, default 4; number of 32-bit words per operand, legal range 2..8.
REQ-002 Port: clock  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request new operation; sampled only in IDLE.
REQ-005 Port: a  input  32*WORDS  operand A.
REQ-006 Port: b  input  32*WORDS  operand B.
REQ-007 Port: ci  input  1  carry-in to word 0.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse: s/co valid and updated.
REQ-010 Port: s  output  32*WORDS  result, registered.
REQ-011 Port: co  output  1  carry-out of the top word, registered.

Function
REQ-012 Block SHALL compute {co,s} = a + b + ci using exactly one shared 32-bit adder instance, one word per cycle, least-significant word first.
REQ-013 FSM SHALL have states IDLE, RUN, DONE; encoding implementation-defined.
REQ-014 IDLE: on start=1 at a rising edge, a, b and ci SHALL be latched into internal registers, word index cleared to 0, carry register loaded with ci, state -> RUN.
REQ-015 RUN: each cycle, word[idx] of s SHALL be written with the 32-bit sum of latched word[idx] of a and b plus carry register; carry register takes that word's carry-out; idx increments.
REQ-016 RUN -> DONE SHALL occur on the edge that writes word WORDS-1; co SHALL be written from that word's carry-out on the same edge.
REQ-017 DONE: done=1 for exactly one cycle, then state -> IDLE unconditionally; start during DONE SHALL be ignored.
REQ-018 Latency: with start sampled at edge N, done SHALL be high in the cycle after edge N+WORDS (WORDS+1 cycles start-to-done).
REQ-019 busy SHALL be 1 in RUN and DONE, 0 in IDLE; busy is a registered output.
REQ-020 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 Changes on a, b, ci after the start edge SHALL NOT affect the result in progress.
REQ-022 s and co SHALL hold their last values between done pulses; partially written words of s during RUN are not guaranteed valid.
REQ-023 Arithmetic SHALL be unsigned modulo 2^(32*WORDS); overflow reported only via co.
REQ-024 Back-to-back operation: start held high SHALL launch a new operation every WORDS+2 cycles (IDLE, WORDS x RUN, DONE).

Reset
REQ-025 reset=1 at a rising edge SHALL force state IDLE, busy=0, done=0, s=0, co=0, idx=0, carry register=0.
REQ-026 reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-027 First start after reset deasserts SHALL be accepted on the first edge with reset=0.

Configuration
REQ-028 Macro ADD_SEQ_SUB_EN, when defined, SHALL add input port sub (1 bit), sampled with start.
REQ-029 With ADD_SEQ_SUB_EN and sub=1: result SHALL be a + ~b + 1 (ci ignored), co=1 meaning no borrow; sub=0 behaves as addition.
REQ-030 Without ADD_SEQ_SUB_EN: no sub port exists; block SHALL perform addition only, identical timing.

Verification (WORDS=4)
REQ-031 a=0, b=0, ci=0, start one cycle -> done 5 cycles after start edge; s=0, co=0; busy high 5 cycles.
REQ-032 a=all-ones (128 bits), b=0, ci=1 -> s=0, co=1 (carry ripples through all four words).
REQ-033 a=0x0000FFFF_0000FFFF_0000FFFF_0000FFFF, b=0xFFFF0000_FFFF0000_FFFF0000_FFFF0000, ci=0 -> s=all-ones, co=0; second start pulsed while busy -> ignored, exactly one done.
REQ-034 a=...135FA562 (low word), b=...35614642, upper words 0 -> s low word 0x48C0EBA4, upper words 0, co=0; operands changed after start edge -> result unchanged.
REQ-035 reset asserted 2 cycles after start -> busy=0, s=0, co=0 next cycle, no done pulse; new start afterward completes normally.
REQ-036 ADD_SEQ_SUB_EN defined, a=5, b=7, sub=1 -> s=all-ones minus 1 (0xFFFF...FFFE), co=0; a=7, b=5, sub=1 -> s=2, co=1.
